// File: rtl/reg_apb_bridge.sv
// APB register front end: decodes paddr into a sub-block select and a 12-bit offset,
// pulses a per-sub-block write enable and muxes read data back with programmable wait states.
module reg_apb_bridge #(
  parameter int NUM_SUB  = 4,
  parameter int WAIT_CYC = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [15:0]           paddr,
  input  logic [31:0]           pwdata,
  output logic [31:0]           prdata,
  output logic                  pready,
  output logic                  pslverr,
  output logic [11:0]           sub_reg_addr,
  output logic [31:0]           reg_wr_data,
  output logic [NUM_SUB-1:0]    reg_wr_en,
  input  logic [NUM_SUB*32-1:0] reg_rd_data
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]         state;
  logic [3:0]         cnt;
  logic               lat_write;
  logic [3:0]         lat_idx;
  logic               err;
  logic [31:0]        sel_data;
  logic [NUM_SUB-1:0] wr_mask;

  // Misalignment is taken from the latched offset, which already carries paddr[1:0].
  always_comb begin
    err      = ({1'b0, lat_idx} >= 5'(NUM_SUB)) || (sub_reg_addr[1:0] != 2'b00);
    sel_data = '0;
    wr_mask  = '0;
    for (int unsigned i = 0; i < NUM_SUB; i++) begin
      if (lat_idx == 4'(i)) begin
        sel_data   = reg_rd_data[32*i +: 32];
        wr_mask[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      lat_write    <= 1'b0;
      lat_idx      <= '0;
      prdata       <= '0;
      pready       <= 1'b0;
      pslverr      <= 1'b0;
      sub_reg_addr <= '0;
      reg_wr_data  <= '0;
      reg_wr_en    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (psel && !penable) begin
            sub_reg_addr <= paddr[11:0];
            reg_wr_data  <= pwdata;
            lat_write    <= pwrite;
            lat_idx      <= paddr[15:12];
            cnt          <= '0;
            state        <= WAIT;
          end
        end
        WAIT: begin
          if (!psel) begin
            state <= IDLE;
          end else if (cnt == 4'(WAIT_CYC)) begin
            state   <= DONE;
            pready  <= 1'b1;
            pslverr <= err;
            if (lat_write) begin
              if (!err) reg_wr_en <= wr_mask;
            end else begin
              prdata <= err ? '0 : sel_data;
            end
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        DONE: begin
          pready    <= 1'b0;
          pslverr   <= 1'b0;
          reg_wr_en <= '0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_apb_bridge.sv
// Scoreboard bench for reg_apb_bridge: driver pushes expected responses from a register-map
// model, a monitor pops and compares on every pready, and sub-blocks are modelled as memories.
module tb_reg_apb_bridge;
  localparam int NUM_SUB  = 4;
  localparam int WAIT_CYC = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  psel, penable, pwrite;
  logic [15:0]           paddr;
  logic [31:0]           pwdata;
  logic [31:0]           prdata;
  logic                  pready, pslverr;
  logic [11:0]           sub_reg_addr;
  logic [31:0]           reg_wr_data;
  logic [NUM_SUB-1:0]    reg_wr_en;
  logic [NUM_SUB*32-1:0] reg_rd_data;

  reg_apb_bridge #(.NUM_SUB(NUM_SUB), .WAIT_CYC(WAIT_CYC)) dut (
    .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
    .pslverr(pslverr), .sub_reg_addr(sub_reg_addr), .reg_wr_data(reg_wr_data),
    .reg_wr_en(reg_wr_en), .reg_rd_data(reg_rd_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input int s, input int w);
    return 32'hA500_0000 ^ (32'(s) << 16) ^ (32'(w) * 32'h0000_9E37);
  endfunction

  // Sub-block environment: committed by the DUT's write pulses at the end of DONE.
  logic [31:0] sub_mem [NUM_SUB][1024];
  bit          sub_vld [NUM_SUB][1024];

  always_comb begin
    reg_rd_data = '0;
    for (int i = 0; i < NUM_SUB; i++)
      reg_rd_data[32*i +: 32] = sub_vld[i][sub_reg_addr[11:2]] ?
                                sub_mem[i][sub_reg_addr[11:2]] :
                                init_word(i, int'(sub_reg_addr[11:2]));
  end

  always @(posedge clk) begin
    for (int i = 0; i < NUM_SUB; i++)
      if (reg_wr_en[i]) begin
        sub_mem[i][sub_reg_addr[11:2]] <= reg_wr_data;
        sub_vld[i][sub_reg_addr[11:2]] <= 1'b1;
      end
  end

  // Reference register map, updated only from the transactions the driver issues.
  logic [31:0] ref_mem [NUM_SUB][1024];
  logic [31:0] last_prdata;

  typedef struct {
    logic [31:0]        prdata;
    logic               err;
    logic [NUM_SUB-1:0] wen;
    logic [11:0]        addr;
    logic [31:0]        wdata;
    int                 cyc;
  } exp_t;

  exp_t sb[$];

  always @(negedge clk) begin
    exp_t e;
    if (pready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pready actual=1 expected=0 (t=%0t)", $time);
      end else begin
        e = sb.pop_front();
        chk("latency",      64'(cyc),          64'(e.cyc));
        chk("prdata",       64'(prdata),       64'(e.prdata));
        chk("pslverr",      64'(pslverr),      64'(e.err));
        chk("reg_wr_en",    64'(reg_wr_en),    64'(e.wen));
        chk("sub_reg_addr", 64'(sub_reg_addr), 64'(e.addr));
        chk("reg_wr_data",  64'(reg_wr_data),  64'(e.wdata));
      end
    end else if (reg_wr_en != '0 || pslverr) begin
      checks++;
      failures++;
      $display("FAIL strobe_without_pready actual=%0h expected=0 (t=%0t)", {reg_wr_en, pslverr}, $time);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic do_xfer(input bit wr, input logic [15:0] a, input logic [31:0] d);
    exp_t e;
    int   idx;
    int   n;
    idx     = int'(a[15:12]);
    e.err   = (idx >= NUM_SUB) || (a[1:0] != 2'b00);
    e.wen   = '0;
    e.addr  = a[11:0];
    e.wdata = d;
    e.cyc   = cyc + 2 + WAIT_CYC;
    if (wr) begin
      e.prdata = last_prdata;
      if (!e.err) begin
        e.wen[idx] = 1'b1;
        ref_mem[idx][a[11:2]] = d;
      end
    end else begin
      e.prdata = e.err ? 32'h0 : ref_mem[idx][a[11:2]];
      last_prdata = e.prdata;
    end
    sb.push_back(e);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    tick();
    penable = 1'b1;
    n = 0;
    while (!pready && n < 40) begin
      tick();
      n++;
    end
    if (n >= 40) chk("pready_timeout", 64'(pready), 64'd1);
    tick();
    idle_bus();
  endtask

  task automatic do_abort(input bit wr, input logic [15:0] a, input logic [31:0] d);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    tick();
    idle_bus();
    repeat (WAIT_CYC + 3) tick();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_prdata"},       64'(prdata),       64'd0);
    chk({tag, "_pready"},       64'(pready),       64'd0);
    chk({tag, "_pslverr"},      64'(pslverr),      64'd0);
    chk({tag, "_sub_reg_addr"}, 64'(sub_reg_addr), 64'd0);
    chk({tag, "_reg_wr_data"},  64'(reg_wr_data),  64'd0);
    chk({tag, "_reg_wr_en"},    64'(reg_wr_en),    64'd0);
  endtask

  initial begin
    bit          wr;
    logic [15:0] a;
    logic [31:0] d;
    for (int i = 0; i < NUM_SUB; i++)
      for (int w = 0; w < 1024; w++)
        ref_mem[i][w] = init_word(i, w);
    last_prdata = 32'h0;
    rst = 1'b1; paddr = '0; pwdata = '0;
    idle_bus();
    repeat (3) tick();
    chk_reset_outputs("reset");
    rst = 1'b0;
    tick();

    do_xfer(1'b1, 16'h1004, 32'h0000_005A);
    do_xfer(1'b1, 16'h0008, 32'h1234_5678);
    do_xfer(1'b0, 16'h0008, 32'h0);
    do_xfer(1'b1, 16'h5000, 32'hCAFE_F00D);
    do_xfer(1'b0, 16'h5000, 32'h0);
    do_xfer(1'b0, 16'h1002, 32'h0);
    do_xfer(1'b0, 16'h1000, 32'h0);
    do_xfer(1'b1, 16'h200C, 32'hDEAD_BEEF);
    do_xfer(1'b0, 16'h200C, 32'h0);
    do_xfer(1'b0, 16'h1004, 32'h0);

    do_abort(1'b1, 16'h3010, 32'h0BAD_0BAD);
    do_xfer(1'b0, 16'h3010, 32'h0);

    // Reset while the write is still waiting: no pulse may ever follow.
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'h3014; pwdata = 32'h5555_AAAA;
    tick();
    penable = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    chk_reset_outputs("midreset");
    rst = 1'b0;
    idle_bus();
    last_prdata = 32'h0;
    repeat (WAIT_CYC + 3) tick();
    do_xfer(1'b0, 16'h3014, 32'h0);
    do_xfer(1'b1, 16'h3014, 32'h7777_0001);
    do_xfer(1'b0, 16'h3014, 32'h0);

    for (int k = 0; k < 300; k++) begin
      wr = 1'($urandom_range(0, 1));
      a  = {4'($urandom_range(0, NUM_SUB + 1)), 6'h0, 4'($urandom_range(0, 15)), 2'b00};
      if ($urandom_range(0, 5) == 0) a[1:0] = 2'($urandom_range(1, 3));
      d  = $urandom;
      if ($urandom_range(0, 19) == 0) do_abort(wr, a, d);
      else                            do_xfer(wr, a, d);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) tick();
    end

    repeat (10) tick();
    chk("sb_drain", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
